// File: rtl/uart_io_port.sv
// Memory-mapped 8N1 UART for the CPU io bus: DATA register at 0x1000, STATUS at 0x2000.
// TX and RX run independently; RX input is double-synchronized and sampled mid-bit.
module uart_io_port #(
  parameter int WIDTH    = 16,
  parameter int BAUD_DIV = 417
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  input  logic             uart_rx,
  output logic             uart_tx
);

  localparam logic [15:0] ADDR_DATA   = 16'h1000;
  localparam logic [15:0] ADDR_STATUS = 16'h2000;
  localparam logic [15:0] BIT_LAST    = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST   = 16'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic        r_uart_tx;
  logic        r_tx_busy;
  logic [7:0]  r_tx_byte;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [1:0]  r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bitn;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_overrun;
  logic        r_framing_err;

  logic w_wr_data;
  logic w_wr_status;
  logic w_tx_accept;
  logic w_clr_valid;
  logic w_clr_overrun;
  logic w_clr_framing;
  logic w_stop_sample;
  logic w_rx_done;
  logic w_rx_bad;
  logic w_unused_dout;

  assign w_wr_data     = io_wr && (mem_addr == ADDR_DATA);
  assign w_wr_status   = io_wr && (mem_addr == ADDR_STATUS);
  assign w_tx_accept   = w_wr_data && !r_tx_busy;
  assign w_clr_valid   = w_wr_status && dout[1];
  assign w_clr_overrun = w_wr_status && dout[2];
  assign w_clr_framing = w_wr_status && dout[3];
  assign w_stop_sample = (r_rx_state == S_STOP) && (r_rx_cnt == BIT_LAST);
  assign w_rx_done     = w_stop_sample && r_rx_s2;
  assign w_rx_bad      = w_stop_sample && !r_rx_s2;
  assign w_unused_dout = &{1'b0, dout[WIDTH-1:8]};

  assign uart_tx = r_uart_tx;

  // r_tx_bit indexes the frame slot currently on the line: 0 start, 1..8 data, 9 stop.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_uart_tx <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_byte <= 8'h00;
      r_tx_cnt  <= 16'd0;
      r_tx_bit  <= 4'd0;
    end else if (w_tx_accept) begin
      r_uart_tx <= 1'b0;
      r_tx_busy <= 1'b1;
      r_tx_byte <= dout[7:0];
      r_tx_cnt  <= 16'd0;
      r_tx_bit  <= 4'd0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == BIT_LAST) begin
        r_tx_cnt <= 16'd0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_uart_tx <= 1'b1;
          r_tx_bit  <= 4'd0;
        end else begin
          r_tx_bit  <= r_tx_bit + 4'd1;
          r_uart_tx <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_byte[r_tx_bit[2:0]];
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bitn  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= 16'd0;
          if (!r_rx_s2) r_rx_state <= S_START;
        end
        // Re-check the start bit near its middle to reject short glitches.
        S_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_bitn  <= 3'd0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bitn  <= r_rx_bitn + 3'd1;
            if (r_rx_bitn == 3'd7) r_rx_state <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Status flags: a completing event always beats a same-cycle software clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      if (w_rx_done) r_rx_data <= r_rx_shift;

      if (w_rx_done)        r_rx_valid <= 1'b1;
      else if (w_clr_valid) r_rx_valid <= 1'b0;

      if (w_rx_done && r_rx_valid && !w_clr_valid) r_overrun <= 1'b1;
      else if (w_clr_overrun)                      r_overrun <= 1'b0;

      if (w_rx_bad)           r_framing_err <= 1'b1;
      else if (w_clr_framing) r_framing_err <= 1'b0;
    end
  end

  always_comb begin
    io_din = '0;
    case (mem_addr)
      ADDR_DATA:   io_din = WIDTH'(r_rx_data);
      ADDR_STATUS: io_din = WIDTH'({r_framing_err, r_overrun, r_rx_valid, r_tx_busy});
      default:     io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_io_port.sv
// Self-checking bench for uart_io_port at BAUD_DIV=8: register vector table, directed
// frame sequences and randomized TX/RX frames against a flag-level reference model.
module tb_uart_io_port;

  localparam int BD = 8;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;
  logic        uart_rx;
  logic        uart_tx;

  uart_io_port #(.WIDTH(16), .BAUD_DIV(BD)) dut (
    .clk(clk), .resetq(resetq), .io_wr(io_wr), .mem_addr(mem_addr), .dout(dout),
    .io_din(io_din), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the software-visible RX state
  logic [7:0] m_data;
  bit m_valid, m_ovr, m_ferr;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%04h, expected 0x%04h", nm, $time, act, exp);
    end
  endtask

  task automatic read_chk(input string nm, input logic [15:0] addr, input logic [15:0] exp);
    mem_addr = addr;
    #1;
    chk(nm, io_din, exp);
  endtask

  function automatic logic [15:0] exp_status(input bit busy);
    return {12'h000, m_ferr, m_ovr, m_valid, busy};
  endfunction

  task automatic check_regs(input string tag);
    read_chk({tag, "_status"}, A_STAT, exp_status(1'b0));
    read_chk({tag, "_data"}, A_DATA, {8'h00, m_data});
    $display("%s: status=0x%04h data=0x%02h", tag, exp_status(1'b0), m_data);
  endtask

  task automatic write_status(input logic [15:0] v);
    @(negedge clk);
    io_wr = 1'b1; mem_addr = A_STAT; dout = v;
    @(negedge clk);
    io_wr = 1'b0;
    if (v[1]) m_valid = 1'b0;
    if (v[2]) m_ovr   = 1'b0;
    if (v[3]) m_ferr  = 1'b0;
  endtask

  // One 82-cycle window: optional TX byte, optional RX frame, optional status clear,
  // optional ignored DATA write, optional reset. Line and busy are checked every cycle.
  task automatic frame_pair(input bit pre, input bit do_tx, input logic [7:0] txb, input int inj,
                            input bit do_rx, input logic [7:0] rxb, input bit rx_stop,
                            input int clr_at, input logic [15:0] clr_val, input int rst_at);
    logic [9:0] tfr;
    logic [9:0] rfr;
    bit valid_before;
    bit exp_tx, exp_busy;
    tfr = {1'b1, txb, 1'b0};
    rfr = {rx_stop, rxb, 1'b0};
    valid_before = m_valid;
    if (!pre) @(negedge clk);
    io_wr = 1'b0;
    uart_rx = do_rx ? rfr[0] : 1'b1;
    if (do_tx) begin
      io_wr = 1'b1; mem_addr = A_DATA; dout = {8'($urandom), txb};
    end
    for (int n = 1; n <= 81; n++) begin
      @(negedge clk);
      io_wr = 1'b0;
      mem_addr = A_STAT;
      uart_rx = (do_rx && n < 80) ? rfr[n / 8] : 1'b1;
      if (n == rst_at) begin
        resetq = 1'b0;
        uart_rx = 1'b1;
        #1;
        chk("rst_tx_line", 16'(uart_tx), 16'h0001);
        read_chk("rst_status", A_STAT, 16'h0000);
        read_chk("rst_data", A_DATA, 16'h0000);
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
        @(negedge clk);
        chk("post_rst_tx_line", 16'(uart_tx), 16'h0001);
        read_chk("post_rst_status", A_STAT, 16'h0000);
        $display("reset at cycle %0d: line and registers cleared", n);
        return;
      end
      #1;
      if (do_tx) begin
        exp_tx   = (n <= 80) ? tfr[(n - 1) / BD] : 1'b1;
        exp_busy = (n <= 80);
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0;
      end
      chk("tx_line", 16'(uart_tx), 16'(exp_tx));
      chk("tx_busy", 16'(io_din[0]), 16'(exp_busy));
      if (n == inj) begin
        io_wr = 1'b1; mem_addr = A_DATA; dout = 16'($urandom);
      end
      if (n == clr_at) begin
        io_wr = 1'b1; mem_addr = A_STAT; dout = clr_val;
      end
    end
    // Clears take effect first; a same-cycle setting event then wins.
    if (clr_at > 0) begin
      if (clr_val[1]) m_valid = 1'b0;
      if (clr_val[2]) m_ovr   = 1'b0;
      if (clr_val[3]) m_ferr  = 1'b0;
    end
    if (do_rx) begin
      if (rx_stop) begin
        if (valid_before && !(clr_at > 0 && clr_val[1])) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = rxb;
      end else begin
        m_ferr = 1'b1;
      end
    end
    $display("frame tx=%0d:0x%02h rx=%0d:0x%02h stop=%0d clr@%0d=0x%04h", do_tx, txb, do_rx, rxb,
             rx_stop, clr_at, clr_val);
    check_regs("frame");
  endtask

  task automatic glitch(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check_regs("glitch");
  endtask

  initial begin
    resetq = 1'b0; io_wr = 1'b0; mem_addr = 16'h0000; dout = 16'h0000; uart_rx = 1'b1;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_line", 16'(uart_tx), 16'h0001);
    resetq = 1'b1;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, A_DATA,   16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, A_STAT,   16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h2001, 16'h0000};
    vecs[3] = '{1'b1, 16'h3000, 16'h00FF, A_STAT,   16'h0000};
    vecs[4] = '{1'b1, 16'h1001, 16'h0055, A_STAT,   16'h0000};
    vecs[5] = '{1'b1, A_STAT,   16'hFFFF, A_STAT,   16'h0000};
    vecs[6] = '{1'b1, A_DATA,   16'h0042, A_STAT,   16'h0001};
    vecs[7] = '{1'b1, A_DATA,   16'h0099, A_STAT,   16'h0001};
    vecs[8] = '{1'b1, A_STAT,   16'hFFFF, A_STAT,   16'h0001};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, A_DATA,   16'h0000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      io_wr = vecs[i].wr; mem_addr = vecs[i].addr; dout = vecs[i].wdata;
      @(negedge clk);
      io_wr = 1'b0;
      read_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      $display("vec%0d wr=%0d addr=0x%04h data=0x%04h read 0x%04h -> 0x%04h", i, vecs[i].wr,
               vecs[i].addr, vecs[i].wdata, vecs[i].raddr, vecs[i].exp);
    end
    repeat (90) @(negedge clk);
    read_chk("table_tx_done", A_STAT, 16'h0000);

    frame_pair(0, 1, 8'hA5, -1, 0, 8'h00, 1, -1, 16'h0000, -1);
    frame_pair(0, 1, 8'h3C, 21, 0, 8'h00, 1, -1, 16'h0000, -1);
    frame_pair(1, 1, 8'h81, -1, 0, 8'h00, 1, -1, 16'h0000, -1);

    frame_pair(0, 0, 8'h00, -1, 1, 8'h3C, 1, -1, 16'h0000, -1);
    write_status(16'h0002);
    check_regs("clr_valid");

    frame_pair(0, 0, 8'h00, -1, 1, 8'h11, 1, -1, 16'h0000, -1);
    frame_pair(0, 0, 8'h00, -1, 1, 8'h22, 1, -1, 16'h0000, -1);
    glitch(3);
    frame_pair(0, 0, 8'h00, -1, 1, 8'h77, 0, -1, 16'h0000, -1);

    write_status(16'h0004);
    check_regs("clr_ovr");
    frame_pair(0, 0, 8'h00, -1, 1, 8'h5A, 1, 78, 16'h0002, -1);
    frame_pair(0, 0, 8'h00, -1, 1, 8'hC3, 0, 78, 16'h0008, -1);
    frame_pair(0, 0, 8'h00, -1, 1, 8'h66, 1, 78, 16'h0004, -1);
    write_status(16'h000E);
    check_regs("clr_all");

    frame_pair(0, 1, 8'h96, -1, 1, 8'h69, 1, -1, 16'h0000, -1);
    frame_pair(0, 1, 8'hF0, -1, 1, 8'h0F, 1, -1, 16'h0000, 36);
    check_regs("after_reset");

    for (int i = 0; i < 10; i++) begin
      bit dt, dr, st;
      int ca;
      dt = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) != 0);
      ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 78)) : -1;
      frame_pair(0, dt, 8'($urandom), -1, dr, 8'($urandom), st, ca, 16'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_io_port.md
UART_IO_PORT -- requirements
Module: uart_io_port

Interface
REQ-001 Parameter WIDTH, default 16, data-path width matching the CPU io bus.
REQ-002 Parameter BAUD_DIV, default 417, clock cycles per UART bit (legal range 4..65535).
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port resetq  input  1  reset, asynchronous and active-low.
REQ-005 Port io_wr  input  1  CPU io write strobe, sampled at rising clk.
REQ-006 Port mem_addr  input  16  CPU io address, valid with io_wr and for io reads.
REQ-007 Port dout  input  WIDTH  CPU io write data.
REQ-008 Port io_din  output  WIDTH  io read data returned to CPU.
REQ-009 Port uart_rx  input  1  asynchronous serial input, idle high.
REQ-010 Port uart_tx  output  1  serial output, idle high.

Function
REQ-011 Address map: 0x1000 = DATA, 0x2000 = STATUS; all other addresses are unmapped.
REQ-012 io_din SHALL be combinational from mem_addr and state, with zero cycles latency: DATA -> rx_data zero-extended; STATUS -> {0..., framing_err[3], overrun[2], rx_valid[1], tx_busy[0]}; unmapped -> 0.
REQ-013 Reads SHALL have no side effects.
REQ-014 io_wr with mem_addr = DATA while tx_busy = 0 SHALL latch dout[7:0] and set tx_busy at that edge; the same write while tx_busy = 1 is ignored.
REQ-015 TX frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV cycles; uart_tx is registered and goes low at the accepting edge.
REQ-016 tx_busy SHALL clear exactly 10*BAUD_DIV cycles after the accepting edge, with uart_tx = 1 at that point; a new write is accepted in that same cycle.
REQ-017 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-018 RX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE -> START on synchronized 0.
REQ-020 START: wait BAUD_DIV/2 cycles and resample; 0 -> DATA, 1 -> IDLE (false start, no flag change).
REQ-021 DATA: sample 8 bits at BAUD_DIV intervals, LSB first; then -> STOP.
REQ-022 STOP: sample after BAUD_DIV cycles; 1 -> load rx_data, set rx_valid, -> IDLE; 0 -> discard byte, set framing_err, -> IDLE (rx_data unchanged).
REQ-023 A byte completing while rx_valid = 1 SHALL overwrite rx_data and set overrun.
REQ-024 io_wr to STATUS: dout[1]=1 clears rx_valid, dout[2]=1 clears overrun, dout[3]=1 clears framing_err; other bits are ignored.
REQ-025 Same-cycle clear of rx_valid and byte completion: completion wins (rx_valid = 1, overrun not set).
REQ-026 Same-cycle clear of overrun/framing_err and a new setting event: the set wins.
REQ-027 TX and RX SHALL operate fully independently; simultaneous activity is legal.
REQ-028 Writes to unmapped addresses SHALL be ignored.

Reset
REQ-029 resetq low asynchronously forces: uart_tx=1, tx_busy=0, rx_valid=0, overrun=0, framing_err=0, rx_data=0, RX FSM=IDLE, synchronizer flops=1, all counters=0.
REQ-030 Reset mid-frame SHALL abort TX (line high immediately) and RX (partial byte discarded); normal operation resumes on the first edge after release.

Verification (BAUD_DIV=8)
REQ-031 Write DATA=0x00A5 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1 (each 8 cycles); STATUS bit0 = 1 for exactly 80 cycles.
REQ-032 Second DATA write at cycle 20 of a frame -> ignored, frame unchanged; write at cycle 80 -> accepted.
REQ-033 Drive RX frame 0x3C -> after stop sample, STATUS=0x0002 and DATA read=0x003C; write STATUS=0x0002 -> STATUS=0x0000.
REQ-034 Two RX frames 0x11 then 0x22 without clearing -> DATA=0x0022, STATUS=0x0006; 3-cycle low glitch on uart_rx -> no state change.
REQ-035 RX frame with stop bit 0 -> STATUS bit3 = 1, DATA unchanged.
REQ-036 Assert resetq low at TX bit 4 and RX bit 4 -> uart_tx=1 immediately, STATUS=0x0000, DATA=0x0000.
